// File: rtl/dense_pkg.sv
// Shared constants, state encoding and weight/bias tables for the dense classifier.
package dense_pkg;

    localparam int N_FEAT  = 20;
    localparam int N_CLASS = 10;
    localparam int X_W     = 6;
    localparam int W_W     = 4;
    localparam int ACC_W   = 17;

    localparam logic [4:0] F_LAST = 5'(N_FEAT - 1);
    localparam logic [3:0] C_LAST = 4'(N_CLASS - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MAC   = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic signed [W_W-1:0] DENSE_W [N_CLASS][N_FEAT] = '{
        '{ 4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,
           4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1},
        '{-4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1,
          -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1},
        '{ 4'sd2, -4'sd2,  4'sd2, -4'sd2,  4'sd2, -4'sd2,  4'sd2, -4'sd2,  4'sd2, -4'sd2,
           4'sd2, -4'sd2,  4'sd2, -4'sd2,  4'sd2, -4'sd2,  4'sd2, -4'sd2,  4'sd2, -4'sd2},
        '{ 4'sd3,  4'sd3,  4'sd3,  4'sd3,  4'sd3,  4'sd3,  4'sd3,  4'sd3,  4'sd3,  4'sd3,
          -4'sd3, -4'sd3, -4'sd3, -4'sd3, -4'sd3, -4'sd3, -4'sd3, -4'sd3, -4'sd3, -4'sd3},
        '{ 4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,
           4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0},
        '{ 4'sd7,  4'sd7,  4'sd7,  4'sd7,  4'sd7,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,
           4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0},
        '{-4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2,
          -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2},
        '{ 4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,
           4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd7,  4'sd7,  4'sd7,  4'sd7,  4'sd7},
        '{ 4'sd1,  4'sd0,  4'sd1,  4'sd0,  4'sd1,  4'sd0,  4'sd1,  4'sd0,  4'sd1,  4'sd0,
           4'sd1,  4'sd0,  4'sd1,  4'sd0,  4'sd1,  4'sd0,  4'sd1,  4'sd0,  4'sd1,  4'sd0},
        '{-4'sd7,  4'sd7, -4'sd7,  4'sd7, -4'sd7,  4'sd7, -4'sd7,  4'sd7, -4'sd7,  4'sd7,
          -4'sd7,  4'sd7, -4'sd7,  4'sd7, -4'sd7,  4'sd7, -4'sd7,  4'sd7, -4'sd7,  4'sd7}
    };

    localparam logic signed [ACC_W-1:0] DENSE_BIAS [N_CLASS] = '{
        -17'sd40, -17'sd40, -17'sd16, 17'sd0, 17'sd48,
        -17'sd8,   17'sd64,  17'sd0,  17'sd8, -17'sd32
    };

endpackage

// File: rtl/dense_seq_ctrl_if.sv
// Feature input stream and result output stream of the dense classifier.
interface dense_seq_ctrl_if;
    import dense_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [X_W-1:0]          in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_CLASS-1:0]      out_onehot;
    logic [3:0]              out_idx;
    logic signed [ACC_W-1:0] out_score;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_onehot, out_idx, out_score
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_onehot, out_idx, out_score
    );

endinterface

// File: rtl/dense_weight_rom.sv
// Combinational (class, feature) -> (weight, bias) lookup from the package tables.
module dense_weight_rom
    import dense_pkg::*;
(
    input  logic [3:0]              c,
    input  logic [4:0]              f,
    output logic signed [W_W-1:0]   w,
    output logic signed [ACC_W-1:0] bias
);

    // Out-of-range indices read as zero.
    always_comb begin
        w    = '0;
        bias = '0;
        if (c < 4'(N_CLASS)) begin
            bias = DENSE_BIAS[c];
            if (f < 5'(N_FEAT)) begin
                w = DENSE_W[c][f];
            end
        end
    end

endmodule

// File: rtl/dense_seq_ctrl.sv
// Sequential dense classifier: buffer a frame, one MAC per cycle, running signed argmax.
module dense_seq_ctrl
    import dense_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            soft_clr,
    dense_seq_ctrl_if.slave bus,
    output logic            busy
);

    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_MAC   = MAC;
    localparam logic [1:0] ST_FINAL = FINAL;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]              state;
    logic [4:0]              f;
    logic [3:0]              c;
    logic [X_W-1:0]          fbuf [N_FEAT];
    logic signed [ACC_W-1:0] score [N_CLASS];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] max_r;
    logic [3:0]              idx_r;
    logic signed [W_W-1:0]   w;
    logic signed [ACC_W-1:0] bias;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] total;
    logic [N_CLASS-1:0]      onehot;
    logic                    accept;

    dense_weight_rom u_rom (
        .c    (c),
        .f    (f),
        .w    (w),
        .bias (bias)
    );

    assign bus.in_ready = (state == ST_LOAD) && !rst;
    assign busy         = (state != ST_LOAD);
    assign accept       = bus.in_valid && bus.in_ready;

    // Product of the current weight and buffered feature, accumulated onto bias at f=0.
    always_comb begin
        prod  = ACC_W'(w) * ACC_W'($signed({1'b0, fbuf[f]}));
        total = ((f == '0) ? bias : acc) + prod;
    end

    // Classes whose score equals the running maximum.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < N_CLASS; i++) begin
            onehot[i] = (score[i] == max_r);
        end
    end

    // State and class/feature counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
            f     <= '0;
            c     <= '0;
        end else if (soft_clr) begin
            state <= ST_LOAD;
            f     <= '0;
            c     <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (f == F_LAST) begin
                            state <= ST_MAC;
                            f     <= '0;
                            c     <= '0;
                        end else begin
                            f <= f + 5'd1;
                        end
                    end
                end
                ST_MAC: begin
                    if (f == F_LAST) begin
                        f <= '0;
                        if (c == C_LAST) begin
                            state <= ST_FINAL;
                            c     <= '0;
                        end else begin
                            c <= c + 4'd1;
                        end
                    end else begin
                        f <= f + 5'd1;
                    end
                end
                ST_FINAL: state <= ST_DONE;
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_LOAD;
                        f     <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Feature buffer, written on each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_FEAT; i++) fbuf[i] <= '0;
        end else if (soft_clr) begin
            for (int unsigned i = 0; i < N_FEAT; i++) fbuf[i] <= '0;
        end else if (accept) begin
            fbuf[f] <= bus.in_data;
        end
    end

    // Accumulator, per-class scores and running max; ties keep the lower index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            max_r <= '0;
            idx_r <= '0;
            for (int unsigned i = 0; i < N_CLASS; i++) score[i] <= '0;
        end else if (soft_clr) begin
            acc   <= '0;
            max_r <= '0;
            idx_r <= '0;
            for (int unsigned i = 0; i < N_CLASS; i++) score[i] <= '0;
        end else if (state == ST_MAC) begin
            acc <= total;
            if (f == F_LAST) begin
                score[c] <= total;
                if (c == '0 || total > max_r) begin
                    max_r <= total;
                    idx_r <= c;
                end
            end
        end
    end

    // Result registers, loaded in FINAL and held until the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_onehot <= '0;
            bus.out_idx    <= '0;
            bus.out_score  <= '0;
        end else if (soft_clr) begin
            bus.out_valid  <= 1'b0;
            bus.out_onehot <= '0;
            bus.out_idx    <= '0;
            bus.out_score  <= '0;
        end else if (state == ST_FINAL) begin
            bus.out_valid  <= 1'b1;
            bus.out_onehot <= onehot;
            bus.out_idx    <= idx_r;
            bus.out_score  <= max_r;
        end else if (state == ST_DONE && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Scoreboard bench for dense_seq_ctrl using directed frames with hand-computed results.
module tb_dense_seq_ctrl;
    import dense_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic soft_clr = 1'b0;
    logic busy;

    dense_seq_ctrl_if bus ();

    dense_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .soft_clr (soft_clr),
        .bus      (bus),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CLASS-1:0]      oh;
        logic [3:0]              idx;
        logic signed [ACC_W-1:0] score;
    } res_t;

    res_t expq [$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   beats = 0;
    int   last_hs = 0;
    logic prev_ov = 1'b0;

    logic [X_W-1:0] fz [N_FEAT];
    logic [X_W-1:0] f1 [N_FEAT];
    logic [X_W-1:0] f63 [N_FEAT];
    logic [X_W-1:0] ft2 [N_FEAT];
    logic [X_W-1:0] ft3 [N_FEAT];
    logic [X_W-1:0] fhi [N_FEAT];
    logic [X_W-1:0] flo [N_FEAT];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic give_up(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired, DUT never responded", nm);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    endtask

    task automatic expect_res(input logic [N_CLASS-1:0] oh, input int idx, input int sc);
        res_t r;
        r.oh    = oh;
        r.idx   = idx[3:0];
        r.score = ACC_W'(sc);
        expq.push_back(r);
    endtask

    // Drives beats first..last; starts and ends just after a rising edge.
    task automatic send(input logic [X_W-1:0] fr [N_FEAT], input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            int t;
            if (gaps) begin
                bus.in_valid = 1'b0;
                while ($urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = fr[i];
            t = 0;
            @(negedge clk);
            while (!bus.in_ready) begin
                t++;
                if (t > 1000) give_up("in_ready_wait");
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() != 0) begin
            t++;
            if (t > 2000) give_up("drain");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int t = 0;
        @(negedge clk);
        while (!bus.out_valid) begin
            t++;
            if (t > 400) give_up("out_valid_wait");
            @(negedge clk);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts input handshakes, checks latency, pops and compares results.
    always @(negedge clk) begin
        res_t e;
        if (rst || soft_clr) begin
            beats = 0;
        end else if (bus.in_valid && bus.in_ready) begin
            beats++;
            if (beats == N_FEAT) begin
                beats   = 0;
                last_hs = cyc;
            end
        end
        if (!rst) begin
            if (bus.out_valid && !prev_ov) chk("latency", cyc - last_hs, 202);
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got idx=%0d score=%0d expected no result",
                             bus.out_idx, bus.out_score);
                end else begin
                    e = expq.pop_front();
                    chk("onehot", bus.out_onehot, e.oh);
                    chk("idx", bus.out_idx, e.idx);
                    chk("score", bus.out_score, e.score);
                end
            end
        end
        prev_ov = bus.out_valid;
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N_FEAT; i++) begin
            fz[i]  = '0;
            f1[i]  = 6'd1;
            f63[i] = 6'd63;
            ft2[i] = '0;
            ft3[i] = '0;
            fhi[i] = (i < 5) ? 6'd63 : 6'd0;
            flo[i] = (i >= 15) ? 6'd63 : 6'd0;
        end
        ft2[10] = 6'd39;
        ft2[11] = 6'd49;
        ft3[10] = 6'd40;
        ft3[11] = 6'd48;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_score", bus.out_score, 0);
        chk("rst_idx", bus.out_idx, 0);
        chk("rst_onehot", bus.out_onehot, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_busy", busy, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // Back-to-back directed frames
        expect_res(10'b0001000000, 6, 64);   send(fz, 0, 19, 0);
        expect_res(10'b0000010000, 4, 48);   send(f1, 0, 19, 0);
        expect_res(10'b0000010001, 0, 48);   send(ft2, 0, 19, 0);
        expect_res(10'b0100010001, 0, 48);   send(ft3, 0, 19, 0);
        expect_res(10'b0000100000, 5, 2197); send(fhi, 0, 19, 0);
        expect_res(10'b0010000000, 7, 2205); send(flo, 0, 19, 0);
        expect_res(10'b0010000000, 7, 2205); send(f63, 0, 19, 0);
        drain();

        // Same frames with random input bubbles
        expect_res(10'b0000010000, 4, 48);   send(f1, 0, 19, 1);
        expect_res(10'b0000010001, 0, 48);   send(ft2, 0, 19, 1);
        expect_res(10'b0010000000, 7, 2205); send(f63, 0, 19, 1);
        drain();

        // Output back-pressure while the next frame is already offered
        bus.out_ready = 1'b0;
        expect_res(10'b0000010000, 4, 48);
        send(f1, 0, 19, 0);
        wait_valid();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 6'd63;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_score", bus.out_score, 48);
            chk("hold_idx", bus.out_idx, 4);
            chk("hold_onehot", bus.out_onehot, 10'b0000010000);
            chk("hold_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_data   = '0;
        expect_res(10'b0001000000, 6, 64);
        @(negedge clk);
        chk("ack_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_ack_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        send(fz, 1, 19, 0);
        drain();

        // Asynchronous reset in the middle of MAC
        send(f1, 0, 19, 0);
        repeat (100) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_score", bus.out_score, 0);
        chk("arst_idx", bus.out_idx, 0);
        chk("arst_onehot", bus.out_onehot, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("arst_rel_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        expect_res(10'b0000010001, 0, 48);
        send(ft2, 0, 19, 0);
        drain();

        // soft_clr in the middle of MAC
        send(f1, 0, 19, 0);
        repeat (100) @(posedge clk);
        #1 soft_clr = 1'b1;
        @(negedge clk);
        chk("sc_busy_before", busy, 1);
        @(posedge clk);
        #1 soft_clr = 1'b0;
        @(negedge clk);
        chk("sc_busy", busy, 0);
        chk("sc_in_ready", bus.in_ready, 1);
        chk("sc_out_valid", bus.out_valid, 0);
        chk("sc_score", bus.out_score, 0);
        chk("sc_onehot", bus.out_onehot, 0);
        @(posedge clk);
        #1;

        // soft_clr coincident with an input handshake after a partial frame
        send(f63, 0, 4, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 6'd63;
        soft_clr     = 1'b1;
        @(negedge clk);
        chk("sc_hs_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        soft_clr     = 1'b0;
        bus.in_valid = 1'b0;
        expect_res(10'b0000100000, 5, 2197);
        send(fhi, 0, 19, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
